// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC fetch unit:
// FSM encodings, PC step and instruction field positions.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  localparam logic [31:0] PC_INCR = 32'd4;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 24;
  localparam int OFF_MSB = 23;
  localparam int OFF_LSB = 16;
  localparam int OFF_W   = OFF_MSB - OFF_LSB + 1;

endpackage

// File: rtl/pc_fetch_unit_next_pc.sv
// Combinational next-PC select: sequential, jump,
// or taken branch (jump wins over branch).
module next_pc_logic
  import pc_fetch_pkg::*;
(
  input  logic [31:0]      PC,
  input  logic [OFF_W-1:0] OFFSET,
  input  logic             JUMPENABLE,
  input  logic             BRANCHENABLE,
  input  logic             ZERO,
  output logic [31:0]      NEXT_PC
);

  logic [31:0] pc_plus4;
  logic [31:0] off_ext;
  logic [31:0] target;
  logic        take;

  assign pc_plus4 = PC + PC_INCR;
  assign off_ext  = {{(32-OFF_W-2){OFFSET[OFF_W-1]}},
                     OFFSET, 2'b00};
  assign target   = pc_plus4 + off_ext;
  assign take     = JUMPENABLE | (BRANCHENABLE & ZERO);

  // Pick the redirect target or fall through
  always_comb begin
    NEXT_PC = pc_plus4;
    if (take) NEXT_PC = target;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch unit: start / fetch / execute sequencer that
// holds the PC and latches the fetched instruction.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        INSTR_BUSYWAIT,
  input  logic [31:0] INSTR_READDATA,
  input  logic        DATA_BUSYWAIT,
  input  logic        JUMPENABLE,
  input  logic        BRANCHENABLE,
  input  logic        ZERO,
  output logic        INSTR_READ,
  output logic [31:0] PC,
  output logic [31:0] INSTRUCTION,
  output logic        INSTR_VALID
);

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        read_q;
  logic        valid_q;
  logic [31:0] next_pc_d;

  next_pc_logic u_next_pc (
    .PC           (pc_q),
    .OFFSET       (instr_q[OFF_MSB:OFF_LSB]),
    .JUMPENABLE   (JUMPENABLE),
    .BRANCHENABLE (BRANCHENABLE),
    .ZERO         (ZERO),
    .NEXT_PC      (next_pc_d)
  );

  // Sequencer with registered read/valid outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_START;
      pc_q    <= PC_RESET;
      instr_q <= 32'h0;
      read_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_START: begin
          state_q <= S_FETCH;
          read_q  <= 1'b1;
          valid_q <= 1'b0;
        end
        S_FETCH: begin
          if (!INSTR_BUSYWAIT) begin
            instr_q <= INSTR_READDATA;
            state_q <= S_EXEC;
            read_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!DATA_BUSYWAIT) begin
            pc_q    <= next_pc_d;
            state_q <= S_FETCH;
            read_q  <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_START;
          read_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign PC          = pc_q;
  assign INSTRUCTION = instr_q;
  assign INSTR_READ  = read_q;
  assign INSTR_VALID = valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential flow,
// fetch wait, jump/branch, wrap, exec stall, reset abort.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        INSTR_BUSYWAIT = 1'b0;
  logic [31:0] INSTR_READDATA = 32'h0;
  logic        DATA_BUSYWAIT = 1'b0;
  logic        JUMPENABLE = 1'b0;
  logic        BRANCHENABLE = 1'b0;
  logic        ZERO = 1'b0;
  logic        INSTR_READ;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [31:0] NOP = 32'h0100_0000;

  always #5 CLK = ~CLK;

  pc_fetch_unit #(.PC_RESET(32'h0)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .INSTR_BUSYWAIT (INSTR_BUSYWAIT),
    .INSTR_READDATA (INSTR_READDATA),
    .DATA_BUSYWAIT  (DATA_BUSYWAIT),
    .JUMPENABLE     (JUMPENABLE),
    .BRANCHENABLE   (BRANCHENABLE),
    .ZERO           (ZERO),
    .INSTR_READ     (INSTR_READ),
    .PC             (PC),
    .INSTRUCTION    (INSTRUCTION),
    .INSTR_VALID    (INSTR_VALID)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reset, release, and step through S_START into S_FETCH
  task automatic do_reset();
    RESET = 1'b0;
    INSTR_BUSYWAIT = 1'b0;
    DATA_BUSYWAIT = 1'b0;
    JUMPENABLE = 1'b0;
    BRANCHENABLE = 1'b0;
    ZERO = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    tick();
  endtask

  // One full fetch + execute from S_FETCH, no stalls
  task automatic do_instr(input logic [31:0] ins,
                          input logic j,
                          input logic b,
                          input logic z);
    INSTR_BUSYWAIT = 1'b0;
    INSTR_READDATA = ins;
    tick();
    JUMPENABLE = j;
    BRANCHENABLE = b;
    ZERO = z;
    DATA_BUSYWAIT = 1'b0;
    tick();
    JUMPENABLE = 1'b0;
    BRANCHENABLE = 1'b0;
    ZERO = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    tick();
    n_chk++;
    if (PC !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_pc: got %h exp %h", PC, 32'h0);
    end
    n_chk++;
    if (INSTRUCTION !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_instr: got %h exp 0", INSTRUCTION);
    end
    n_chk++;
    if (INSTR_READ !== 1'b0 || INSTR_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags: read %b valid %b exp 0 0",
               INSTR_READ, INSTR_VALID);
    end
    RESET = 1'b1;
    #1;
    n_chk++;
    if (INSTR_READ !== 1'b0 || INSTR_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL start_flags: read %b valid %b exp 0 0",
               INSTR_READ, INSTR_VALID);
    end
    tick();
    n_chk++;
    if (INSTR_READ !== 1'b1 || PC !== 32'h0) begin
      n_fail++;
      $display("FAIL first_fetch: read %b pc %h exp 1 0",
               INSTR_READ, PC);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] ins;
    for (int i = 0; i < 3; i++) begin
      ins = {8'h10, 8'h05, 16'(i)};
      n_chk++;
      if (PC !== 32'(4*i) || INSTR_READ !== 1'b1 ||
          INSTR_VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_fetch%0d: pc %h rd %b vl %b exp %h 1 0",
                 i, PC, INSTR_READ, INSTR_VALID, 32'(4*i));
      end
      JUMPENABLE = 1'b1;
      INSTR_READDATA = ins;
      tick();
      JUMPENABLE = 1'b0;
      n_chk++;
      if (INSTR_VALID !== 1'b1 || INSTR_READ !== 1'b0 ||
          INSTRUCTION !== ins || PC !== 32'(4*i)) begin
        n_fail++;
        $display("FAIL seq_exec%0d: vl %b rd %b ins %h pc %h exp 1 0 %h %h",
                 i, INSTR_VALID, INSTR_READ, INSTRUCTION, PC,
                 ins, 32'(4*i));
      end
      tick();
    end
    n_chk++;
    if (PC !== 32'd12 || INSTR_READ !== 1'b1) begin
      n_fail++;
      $display("FAIL seq_end: pc %h rd %b exp c 1", PC, INSTR_READ);
    end
  endtask

  task automatic test_fetch_wait();
    int rc;
    rc = 0;
    do_reset();
    do_instr(NOP, 1'b0, 1'b0, 1'b0);
    do_instr(32'h2000_0001, 1'b0, 1'b0, 1'b0);
    INSTR_BUSYWAIT = 1'b1;
    INSTR_READDATA = 32'hBAD0_0000;
    for (int k = 0; k < 3; k++) begin
      if (INSTR_READ === 1'b1) rc++;
      tick();
      n_chk++;
      if (PC !== 32'd8 || INSTRUCTION !== 32'h2000_0001 ||
          INSTR_VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL wait%0d: pc %h ins %h vl %b exp 8 20000001 0",
                 k, PC, INSTRUCTION, INSTR_VALID);
      end
    end
    INSTR_BUSYWAIT = 1'b0;
    INSTR_READDATA = 32'h3300_0000;
    if (INSTR_READ === 1'b1) rc++;
    tick();
    n_chk++;
    if (INSTRUCTION !== 32'h3300_0000 || INSTR_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_cap: ins %h vl %b exp 33000000 1",
               INSTRUCTION, INSTR_VALID);
    end
    n_chk++;
    if (rc !== 4) begin
      n_fail++;
      $display("FAIL wait_rdcnt: got %0d exp 4", rc);
    end
    tick();
  endtask

  task automatic test_jump();
    do_instr(NOP, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (PC !== 32'd16) begin
      n_fail++;
      $display("FAIL jmp_pre: got %h exp 10", PC);
    end
    do_instr({8'h20, 8'hFE, 16'h0}, 1'b1, 1'b0, 1'b0);
    n_chk++;
    if (PC !== 32'd12) begin
      n_fail++;
      $display("FAIL jmp_neg: got %h exp c", PC);
    end
    do_instr(NOP, 1'b0, 1'b0, 1'b0);
    do_instr({8'h20, 8'h03, 16'h0}, 1'b1, 1'b0, 1'b0);
    n_chk++;
    if (PC !== 32'd32) begin
      n_fail++;
      $display("FAIL jmp_pos: got %h exp 20", PC);
    end
  endtask

  task automatic test_branch();
    do_instr({8'h20, 8'hFC, 16'h0}, 1'b1, 1'b0, 1'b0);
    n_chk++;
    if (PC !== 32'd20) begin
      n_fail++;
      $display("FAIL br_pre: got %h exp 14", PC);
    end
    do_instr({8'h30, 8'h02, 16'h0}, 1'b0, 1'b1, 1'b1);
    n_chk++;
    if (PC !== 32'd32) begin
      n_fail++;
      $display("FAIL br_taken: got %h exp 20", PC);
    end
    do_instr({8'h20, 8'hFC, 16'h0}, 1'b1, 1'b0, 1'b0);
    do_instr({8'h30, 8'h02, 16'h0}, 1'b0, 1'b1, 1'b0);
    n_chk++;
    if (PC !== 32'd24) begin
      n_fail++;
      $display("FAIL br_not: got %h exp 18", PC);
    end
    do_instr({8'h30, 8'h01, 16'h0}, 1'b1, 1'b1, 1'b0);
    n_chk++;
    if (PC !== 32'd32) begin
      n_fail++;
      $display("FAIL br_prio: got %h exp 20", PC);
    end
    do_instr({8'h30, 8'h05, 16'h0}, 1'b0, 1'b0, 1'b1);
    n_chk++;
    if (PC !== 32'd36) begin
      n_fail++;
      $display("FAIL zero_only: got %h exp 24", PC);
    end
  endtask

  task automatic test_wrap_stall();
    do_reset();
    do_instr({8'h20, 8'hFE, 16'h0}, 1'b1, 1'b0, 1'b0);
    n_chk++;
    if (PC !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_pre: got %h exp fffffffc", PC);
    end
    INSTR_READDATA = NOP;
    tick();
    DATA_BUSYWAIT = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_chk++;
      if (PC !== 32'hFFFF_FFFC || INSTR_VALID !== 1'b1 ||
          INSTR_READ !== 1'b0) begin
        n_fail++;
        $display("FAIL stall%0d: pc %h vl %b rd %b exp fffffffc 1 0",
                 k, PC, INSTR_VALID, INSTR_READ);
      end
    end
    DATA_BUSYWAIT = 1'b0;
    tick();
    n_chk++;
    if (PC !== 32'h0 || INSTR_VALID !== 1'b0 ||
        INSTR_READ !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap: pc %h vl %b rd %b exp 0 0 1",
               PC, INSTR_VALID, INSTR_READ);
    end
  endtask

  task automatic test_reset_abort();
    do_instr({8'h20, 8'h09, 16'h0}, 1'b1, 1'b0, 1'b0);
    n_chk++;
    if (PC !== 32'd40) begin
      n_fail++;
      $display("FAIL abort_pre: got %h exp 28", PC);
    end
    INSTR_BUSYWAIT = 1'b1;
    tick();
    tick();
    #2;
    RESET = 1'b0;
    #1;
    n_chk++;
    if (PC !== 32'h0 || INSTR_READ !== 1'b0 ||
        INSTR_VALID !== 1'b0 || INSTRUCTION !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_async: pc %h rd %b vl %b ins %h exp 0 0 0 0",
               PC, INSTR_READ, INSTR_VALID, INSTRUCTION);
    end
    INSTR_BUSYWAIT = 1'b0;
    INSTR_READDATA = 32'hDEAD_BEEF;
    tick();
    n_chk++;
    if (INSTRUCTION !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_nocap: got %h exp 0", INSTRUCTION);
    end
    RESET = 1'b1;
    #1;
    n_chk++;
    if (INSTR_READ !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_start: rd %b exp 0", INSTR_READ);
    end
    tick();
    n_chk++;
    if (INSTR_READ !== 1'b1 || PC !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_refetch: rd %b pc %h exp 1 0",
               INSTR_READ, PC);
    end
    INSTR_READDATA = 32'h4400_0000;
    tick();
    n_chk++;
    if (INSTRUCTION !== 32'h4400_0000 || INSTR_VALID !== 1'b1 ||
        PC !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_cap: ins %h vl %b pc %h exp 44000000 1 0",
               INSTRUCTION, INSTR_VALID, PC);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_fetch_wait();
    test_jump();
    test_branch();
    test_wrap_stall();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
